// File: rtl/traffic_light_ctrl.sv
// Two-way intersection lamp controller: steps NS/EW phases on advance edges,
// inserts all-red clearance, and falls back to a blinking flash on request or watchdog fault.
module traffic_light_ctrl #(
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned BLINK_CYCLES = 8,
    parameter int unsigned WDOG_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       flash,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic [2:0] phase,
    output logic       fault
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_EW = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_NS = 3'd5,
        FLASH = 3'd6
    } phase_e;

    localparam logic [15:0] CLR_LAST   = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYCLES - 1);
    localparam logic [15:0] WDOG_LAST  = 16'(WDOG_CYCLES - 1);

    // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

    phase_e      phase_q, phase_d;
    logic        adv_q;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        fault_q, fault_d;
    logic [5:0]  lamps_q, lamps_d;
    logic        adv_edge;
    logic        enter_flash;

    function automatic logic [5:0] lamps_for(input phase_e ph, input logic bl);
        logic [5:0] l;
        case (ph)
            NS_G:    l = 6'b001_100;
            NS_Y:    l = 6'b010_100;
            EW_G:    l = 6'b100_001;
            EW_Y:    l = 6'b100_010;
            FLASH:   l = {1'b0, bl, 1'b0, bl, 2'b00};
            default: l = LAMPS_ALL_RED;
        endcase
        return l;
    endfunction

    assign adv_edge = advance & ~adv_q;

    always_comb begin
        phase_d     = phase_q;
        clr_cnt_d   = clr_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        fault_d     = fault_q;
        enter_flash = 1'b0;

        case (phase_q)
            NS_G, NS_Y, EW_G, EW_Y: begin
                if (flash || fault_q) begin
                    enter_flash = 1'b1;
                end else if (adv_edge) begin
                    wd_cnt_d = 16'd0;
                    if (phase_q == NS_G) begin
                        phase_d = NS_Y;
                    end else if (phase_q == NS_Y) begin
                        phase_d   = AR_EW;
                        clr_cnt_d = 16'd0;
                    end else if (phase_q == EW_G) begin
                        phase_d = EW_Y;
                    end else begin
                        phase_d   = AR_NS;
                        clr_cnt_d = 16'd0;
                    end
                end else if (wd_cnt_q == WDOG_LAST) begin
                    fault_d     = 1'b1;
                    enter_flash = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            AR_EW, AR_NS: begin
                // Advance edges seen during clearance are deliberately discarded.
                if (flash || fault_q) begin
                    enter_flash = 1'b1;
                end else if (clr_cnt_q == CLR_LAST) begin
                    phase_d  = (phase_q == AR_EW) ? EW_G : NS_G;
                    wd_cnt_d = 16'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 16'd1;
                end
            end
            FLASH: begin
                if (!flash && !fault_q) begin
                    phase_d     = AR_NS;
                    clr_cnt_d   = 16'd0;
                    blink_d     = 1'b0;
                    blink_cnt_d = 16'd0;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = 16'd0;
                end else begin
                    blink_cnt_d = blink_cnt_q + 16'd1;
                end
            end
            default: begin
                phase_d   = AR_NS;
                clr_cnt_d = 16'd0;
            end
        endcase

        if (enter_flash) begin
            phase_d     = FLASH;
            blink_d     = 1'b1;
            blink_cnt_d = 16'd0;
        end

        // Lamps are decoded from the next state so they change on the same edge as phase.
        lamps_d = lamps_for(phase_d, blink_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= AR_NS;
            adv_q       <= 1'b0;
            clr_cnt_q   <= 16'd0;
            wd_cnt_q    <= 16'd0;
            blink_cnt_q <= 16'd0;
            blink_q     <= 1'b0;
            fault_q     <= 1'b0;
            lamps_q     <= LAMPS_ALL_RED;
        end else begin
            phase_q     <= phase_d;
            adv_q       <= advance;
            clr_cnt_q   <= clr_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            fault_q     <= fault_d;
            lamps_q     <= lamps_d;
        end
    end

    assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps_q;
    assign phase = phase_q;
    assign fault = fault_q;

endmodule
